// File: rtl/alu_sequencer_pkg.sv
// Shared ALU definitions: op-code constants, sequencer FSM encoding and
// the op legality helper. The ALU itself consumes the same op codes.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_BEQ = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } seq_state_t;

  function automatic logic alu_op_legal(input logic [2:0] op);
    return (op <= ALU_OR);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, ALU-drive and response channels of the ALU sequencer.
// slave is the sequencer's view; master is the surrounding decode/ALU side.
interface alu_sequencer_if #(
  parameter int unsigned TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_ctrl;
  logic [31:0]      alu_r;
  logic             alu_zero;
  logic             alu_ovf;
  logic             alu_branch;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_r;
  logic             rsp_zero;
  logic             rsp_ovf;
  logic             rsp_branch;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag,
    output req_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_r, alu_zero, alu_ovf, alu_branch,
    output rsp_valid, rsp_r, rsp_zero, rsp_ovf, rsp_branch, rsp_err, rsp_tag,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag,
    input  req_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_r, alu_zero, alu_ovf, alu_branch,
    input  rsp_valid, rsp_r, rsp_zero, rsp_ovf, rsp_branch, rsp_err, rsp_tag,
    output rsp_ready
  );
endinterface

// File: rtl/alu_sequencer_rsp_norm.sv
// Combinational normaliser: maps raw ALU outputs to per-op result and flags.
module alu_rsp_norm
  import alu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] alu_r_i,
  input  logic        alu_ovf_i,
  input  logic        alu_branch_i,
  output logic [31:0] r_o,
  output logic        zero_o,
  output logic        ovf_o,
  output logic        branch_o,
  output logic        err_o
);

  always_comb begin
    r_o      = '0;
    ovf_o    = 1'b0;
    branch_o = 1'b0;
    err_o    = 1'b0;
    if (!alu_op_legal(op_i)) begin
      err_o = 1'b1;
    end else begin
      case (op_i)
        ALU_ADD, ALU_SUB: begin
          r_o   = alu_r_i;
          ovf_o = alu_ovf_i;
        end
        ALU_XOR, ALU_OR: r_o = alu_r_i;
        // R may be stale on an equal compare, so it is never forwarded
        ALU_BEQ: branch_o = alu_branch_i;
        default: err_o = 1'b1;
      endcase
    end
    zero_o = (r_o == '0);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Single-outstanding ALU sequencer: issues one op, waits out the registered
// ALU latency, captures the normalised result and returns it with its tag.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus,
  output logic           busy
);

  seq_state_t state_q, state_d;
  logic       issue_en;
  logic       capture_en;

  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [TAG_W-1:0] tag_q;

  logic [31:0]      rsp_r_q;
  logic             rsp_zero_q;
  logic             rsp_ovf_q;
  logic             rsp_branch_q;
  logic             rsp_err_q;
  logic [TAG_W-1:0] rsp_tag_q;

  logic [31:0] norm_r;
  logic        norm_zero;
  logic        norm_ovf;
  logic        norm_branch;
  logic        norm_err;

  always_comb begin
    state_d    = state_q;
    issue_en   = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          issue_en = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_WAIT;
      ST_WAIT: begin
        capture_en = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  alu_rsp_norm u_norm (
    .op_i        (op_q),
    .alu_r_i     (bus.alu_r),
    .alu_ovf_i   (bus.alu_ovf),
    .alu_branch_i(bus.alu_branch),
    .r_o         (norm_r),
    .zero_o      (norm_zero),
    .ovf_o       (norm_ovf),
    .branch_o    (norm_branch),
    .err_o       (norm_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      tag_q        <= '0;
      rsp_r_q      <= '0;
      rsp_zero_q   <= 1'b1;
      rsp_ovf_q    <= 1'b0;
      rsp_branch_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      state_q <= state_d;
      // Issue registers hold between ops so the ALU inputs never toggle idly
      if (issue_en) begin
        op_q  <= bus.req_op;
        a_q   <= bus.req_a;
        b_q   <= bus.req_b;
        tag_q <= bus.req_tag;
      end
      if (capture_en) begin
        rsp_r_q      <= norm_r;
        rsp_zero_q   <= norm_zero;
        rsp_ovf_q    <= norm_ovf;
        rsp_branch_q <= norm_branch;
        rsp_err_q    <= norm_err;
        rsp_tag_q    <= tag_q;
      end
    end
  end

  // Ready is gated by reset so it stays low while reset is asserted
  assign bus.req_ready  = (state_q == ST_IDLE) && reset;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_ctrl   = op_q;
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_r      = rsp_r_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.rsp_branch = rsp_branch_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a registered ALU model.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   failures = 0;

  alu_sequencer_if #(.TAG_W(4)) bus ();

  alu_sequencer #(.TAG_W(4)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Registered ALU: BEQ leaves a junk R and non-arithmetic ops raise ovf,
  // so the sequencer's normalisation is actually exercised.
  always @(posedge clk) begin
    logic [32:0] t;
    case (bus.alu_ctrl)
      3'b000: t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b001: t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      3'b010: t = {1'b1, bus.alu_a ^ bus.alu_b};
      3'b011: t = {1'b1, 32'hDEAD_BEEF};
      3'b100: t = {1'b1, bus.alu_a | bus.alu_b};
      default: t = {1'b1, bus.alu_a + bus.alu_b};
    endcase
    bus.alu_r      <= t[31:0];
    bus.alu_ovf    <= t[32];
    bus.alu_zero   <= (t[31:0] == 32'd0);
    bus.alu_branch <= (bus.alu_a == bus.alu_b);
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    int w;
    @(negedge clk);
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    bus.req_valid = 1'b1;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 12);
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if ({bus.rsp_r, bus.rsp_zero} !== 33'h1) begin failures++; $display("FAIL reset_rsp_r_zero got=%h/%b exp=0/1", bus.rsp_r, bus.rsp_zero); end
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, busy} !== 68'h0) begin failures++; $display("FAIL reset_alu_busy got=%h %h %b %b exp=0", bus.alu_a, bus.alu_b, bus.alu_ctrl, busy); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL release_req_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_add();
    int lat;
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 4'd3);
    wait_rsp(lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", lat); end
    checks++; if (bus.rsp_r !== 32'h0) begin failures++; $display("FAIL add_r got=%h exp=0", bus.rsp_r); end
    checks++; if ({bus.rsp_zero, bus.rsp_ovf, bus.rsp_branch, bus.rsp_err} !== 4'b1100) begin failures++; $display("FAIL add_flags got=%b exp=1100", {bus.rsp_zero, bus.rsp_ovf, bus.rsp_branch, bus.rsp_err}); end
    checks++; if (bus.rsp_tag !== 4'd3) begin failures++; $display("FAIL add_tag got=%0d exp=3", bus.rsp_tag); end
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== {32'hFFFF_FFFF, 32'h1, 3'b000}) begin failures++; $display("FAIL add_issue got=%h %h %b", bus.alu_a, bus.alu_b, bus.alu_ctrl); end
    handshake();
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.req_ready, busy} !== 3'b010) begin failures++; $display("FAIL add_done got=%b exp=010", {bus.rsp_valid, bus.req_ready, busy}); end
  endtask

  task automatic test_beq();
    int lat;
    issue(ALU_BEQ, 32'd5, 32'd5, 4'd1);
    wait_rsp(lat);
    checks++; if ({bus.rsp_r, bus.rsp_branch, bus.rsp_zero, bus.rsp_ovf} !== {32'h0, 3'b110}) begin failures++; $display("FAIL beq_eq got=%h b=%b z=%b o=%b exp=0 1 1 0", bus.rsp_r, bus.rsp_branch, bus.rsp_zero, bus.rsp_ovf); end
    handshake();
    issue(ALU_BEQ, 32'd5, 32'd6, 4'd2);
    wait_rsp(lat);
    checks++; if ({bus.rsp_r, bus.rsp_branch, bus.rsp_tag} !== {32'h0, 1'b0, 4'd2}) begin failures++; $display("FAIL beq_ne got=%h b=%b tag=%0d exp=0 0 2", bus.rsp_r, bus.rsp_branch, bus.rsp_tag); end
    handshake();
  endtask

  task automatic test_stall();
    int lat;
    issue(ALU_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 4'd6);
    wait_rsp(lat);
    checks++; if ({bus.rsp_r, bus.rsp_ovf} !== {32'hA5A5_5A5A, 1'b0}) begin failures++; $display("FAIL xor_r got=%h o=%b exp=a5a55a5a 0", bus.rsp_r, bus.rsp_ovf); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({bus.rsp_valid, bus.req_ready, bus.rsp_r, bus.rsp_tag} !== {2'b10, 32'hA5A5_5A5A, 4'd6}) begin failures++; $display("FAIL stall_hold[%0d] got=v%b rdy%b %h t%0d", i, bus.rsp_valid, bus.req_ready, bus.rsp_r, bus.rsp_tag); end
    end
    handshake();
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin failures++; $display("FAIL stall_release got=%b exp=01", {bus.rsp_valid, bus.req_ready}); end
  endtask

  task automatic test_illegal();
    int lat;
    issue(3'b111, 32'd7, 32'd9, 4'd7);
    wait_rsp(lat);
    checks++; if (bus.alu_ctrl !== 3'b111) begin failures++; $display("FAIL illegal_ctrl got=%b exp=111", bus.alu_ctrl); end
    checks++; if ({bus.rsp_r, bus.rsp_err, bus.rsp_zero, bus.rsp_ovf, bus.rsp_branch} !== {32'h0, 4'b1100}) begin failures++; $display("FAIL illegal_rsp got=%h e=%b z=%b o=%b b=%b", bus.rsp_r, bus.rsp_err, bus.rsp_zero, bus.rsp_ovf, bus.rsp_branch); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    issue(ALU_ADD, 32'd1, 32'd2, 4'd9);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, bus.rsp_valid, bus.req_ready, bus.alu_ctrl} !== 6'b0) begin failures++; $display("FAIL midrst_ctl got=%b%b%b %b exp=0", busy, bus.rsp_valid, bus.req_ready, bus.alu_ctrl); end
    checks++; if ({bus.alu_a, bus.rsp_r, bus.rsp_zero, bus.rsp_tag} !== {64'h0, 1'b1, 4'd0}) begin failures++; $display("FAIL midrst_data got=%h %h z=%b t=%0d", bus.alu_a, bus.rsp_r, bus.rsp_zero, bus.rsp_tag); end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_rsp got=%b exp=0", seen); end
    issue(ALU_SUB, 32'd10, 32'd3, 4'd4);
    wait_rsp(lat);
    checks++; if ({bus.rsp_r, bus.rsp_ovf, bus.rsp_tag, lat[3:0]} !== {32'd7, 1'b0, 4'd4, 4'd3}) begin failures++; $display("FAIL sub_after_rst got=%h o=%b t=%0d lat=%0d exp=7 0 4 3", bus.rsp_r, bus.rsp_ovf, bus.rsp_tag, lat); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int got = 0;
    int t_n[3];
    logic [3:0]  t_tag[3];
    logic [31:0] t_r[3];
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 40 && got < 3; n++) begin
      @(negedge clk);
      if (bus.rsp_valid && got < 3) begin
        t_n[got] = n; t_tag[got] = bus.rsp_tag; t_r[got] = bus.rsp_r;
        got++;
      end
      if (bus.req_ready && k < 3) begin
        bus.req_op = ALU_ADD; bus.req_a = k + 1; bus.req_b = 32'd1;
        bus.req_tag = 4'(5 + k); bus.req_valid = 1'b1;
        k++;
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checks++; if (got !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got); end
    for (int i = 0; i < got; i++) begin
      checks++; if ({t_tag[i], t_r[i]} !== {4'(5 + i), 32'(i + 2)}) begin failures++; $display("FAIL b2b_rsp[%0d] got=t%0d %h exp=t%0d %h", i, t_tag[i], t_r[i], 5 + i, i + 2); end
      if (i > 0) begin
        checks++; if (t_n[i] - t_n[i-1] !== 4) begin failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=4", i, t_n[i] - t_n[i-1]); end
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_beq();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Initiator-side controller for the registered 32-bit ALU. Accepts one operation at a time over a valid/ready request channel and drives the ALU's `A`, `B` and 3-bit `CTRL` inputs. It waits out the ALU's registered latency, captures and normalises `R`, `zero`, `ovf` and `branch`, and returns them with the request tag over a valid/ready response channel. It sits between the decode stage and the ALU, replacing ad-hoc direct drive of ALU inputs.

## Interface
- `TAG_W`, default 4: width of the request/response tag.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; asserted (0) forces all state and outputs to reset values.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept; high only in IDLE.
- `req_op` in 3: ALU op code; ADD=000, SUB=001, XOR=010, BEQ=011, OR=100; 101–111 illegal.
- `req_a`, `req_b` in 32: operands.
- `req_tag` in `TAG_W`: opaque ID, returned unchanged.
- `alu_a`, `alu_b` out 32: to ALU `A`/`B`.
- `alu_ctrl` out 3: to ALU `CTRL`.
- `alu_r` in 32: from ALU `R`.
- `alu_zero`, `alu_ovf`, `alu_branch` in 1: from ALU.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts.
- `rsp_r` out 32: normalised result.
- `rsp_zero`, `rsp_ovf`, `rsp_branch`, `rsp_err` out 1: flags; `rsp_err` marks an illegal op.
- `rsp_tag` out `TAG_W`: tag of the completed op.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE → EXEC → WAIT → RESP → IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, at the edge: latch op, a, b, tag into the issue registers, which drive `alu_*`. Go to EXEC.
- **EXEC**
  - `alu_*` stable; the ALU samples them at the closing edge. Go to WAIT.
- **WAIT**
  - ALU outputs valid. At the edge, capture into the response registers. Go to RESP.
- **RESP**
  - `rsp_valid`=1.
  - When `rsp_valid && rsp_ready`, return to IDLE at the edge.
  - Response registers hold stable while stalled.
- **Normalisation at capture**
  - ADD/SUB: `rsp_r`=`alu_r`, `rsp_ovf`=`alu_ovf`, `rsp_branch`=0.
  - XOR/OR: `rsp_r`=`alu_r`, `rsp_ovf`=0, `rsp_branch`=0.
  - BEQ: `rsp_r`=0, `rsp_branch`=`alu_branch`, `rsp_ovf`=0. The ALU may hold a stale `R` on equal compare, so `rsp_r` is always forced to 0.
  - Illegal op: issued unchanged to the ALU; `rsp_r`=0, `rsp_err`=1, other flags 0.
  - `rsp_zero` = (`rsp_r` == 0), recomputed on the normalised value; the ALU's `zero` is not used for output.
- **`alu_*` outside EXEC/WAIT**
  - Issue registers keep their last value (no toggling).
  - `alu_ctrl` resets to 000.
- **Arithmetic**
  - No arithmetic in this block.
  - `ovf` is the ALU's bit 32 carry/borrow, passed through unsigned.

## Timing
- Request accepted at edge n. `rsp_valid` high from cycle n+3. Minimum 4 cycles per op (one outstanding op, no pipelining).
- Back-to-back: the next `req_ready` comes in the cycle after the RESP handshake.
- `req_ready` depends only on state, never combinationally on `rsp_ready`.
- `rsp_*` are registered outputs, unchanged while `rsp_valid && !rsp_ready`.
- Reset values: state=IDLE, `req_ready`=1 (after release), `rsp_valid`=0, `rsp_r`=0, `rsp_zero`=1, `rsp_ovf`/`rsp_branch`/`rsp_err`=0, `rsp_tag`=0, `alu_a`/`alu_b`=0, `alu_ctrl`=000, `busy`=0.
- `req_ready` is 0 during reset.
- Reset mid-operation (any state): in-flight op discarded, no response emitted. The ALU's own stale `R` is ignored because the next capture only happens after a fresh EXEC.
- `req_valid` while not IDLE: ignored. The requester must hold its request until handshake.

## Structure
- Shared package `alu_pkg`:
  - op-code localparams `ALU_ADD`, `ALU_SUB`, `ALU_XOR`, `ALU_BEQ`, `ALU_OR` (3-bit);
  - the FSM state encoding;
  - helper function `alu_op_legal`.
- The ALU consumes the same op-code constants.
- One sub-module: `alu_rsp_norm`, the combinational normaliser (op + raw ALU outputs → normalised result and flags). Unit-tested on its own.

## Test plan
- ADD 0xFFFF_FFFF + 0x1, tag 3 → `rsp_valid` at n+3: `rsp_r`=0, `rsp_zero`=1, `rsp_ovf`=1, `rsp_tag`=3.
- BEQ 5,5 followed by BEQ 5,6 → first `rsp_branch`=1, `rsp_r`=0; second `rsp_branch`=0, `rsp_r`=0.
- XOR 0xA5A5_0000 ^ 0x0000_5A5A with `rsp_ready` held low 5 cycles → `rsp_r`=0xA5A5_5A5A stable throughout; `req_ready`=0 until the handshake.
- Op 111 with a=7, b=9 → `rsp_err`=1, `rsp_r`=0, `rsp_zero`=1.
- Reset asserted in WAIT → all outputs at reset values asynchronously, no response afterwards; a subsequent SUB 10−3 gives `rsp_r`=7.
- Three back-to-back requests with `rsp_ready`=1 → responses 4 cycles apart, tags in order.
